// File: rtl/core_pkg.sv
// Shared definitions for the CorePipelined front end: datapath width,
// default reset vector, the canonical NOP and the fetch buffer entry layout.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO holding fetched {pc, instr} pairs.
// Flush has priority over enqueue/dequeue; head shows the oldest entry.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q] = enq_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (deq) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  // State registers; storage contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues reads to a 1-cycle
// instruction memory, buffers responses and hands them to decode.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int             XLEN       = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
  parameter int             FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_rd_en_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_flush_o
);

  import core_pkg::NOP;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic               kill_q, kill_d;
  logic [CW-1:0]      count;
  logic [XLEN+31:0]   head;
  logic [CW:0]        occupancy;
  logic               deq, issue, enq;

  // Handshake, issue gating and PC/kill next-state; redirect dominates.
  always_comb begin
    valid_o    = !rst && (count != '0) && !redirect_i;
    deq        = valid_o && ready_i;
    // Slots already committed after this cycle's dequeue; issuing only
    // below depth guarantees the returning word always has a slot.
    occupancy  = {1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(deq);
    issue      = !rst && !redirect_i && (occupancy < (CW + 1)'(FIFO_DEPTH));
    enq        = inflight_q && !kill_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    if (redirect_i) begin
      pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
      kill_d = inflight_q;
    end else if (issue) begin
      pc_d     = pc_q + XLEN'(4);
      req_pc_d = pc_q;
    end
  end

  // PC, request tracking and kill registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN + 32)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_i),
    .enq      (enq),
    .enq_data ({req_pc_q, imem_rdata_i}),
    .deq      (deq),
    .count    (count),
    .head     (head)
  );

  assign imem_rd_en_o = issue;
  assign imem_addr_o  = pc_q;
  assign pc_o         = head[XLEN+31:32];
  assign instr_o      = (count != '0) ? head[31:0] : NOP;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Delivered-instruction and redirect counters, free-running with wrap.
  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'b0, deq};
    perf_flush_d   = perf_flush_q + {31'b0, redirect_i};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flush_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flush_q   <= perf_flush_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_flush_o   = perf_flush_q;
`else
  assign perf_fetched_o = '0;
  assign perf_flush_o   = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default instance plus one with a
// reset vector near the top of the address space to exercise PC wrap.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC1 = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ready_i;
  logic        imem_rd_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_flush_o;

  logic        redirect1;
  logic [31:0] redirect_pc1;
  logic        ready1;
  logic        rd_en1;
  logic [31:0] addr1;
  logic [31:0] rdata1;
  logic        valid1;
  logic [31:0] instr1;
  logic [31:0] pc1;
  logic [31:0] perf_fetched1;
  logic [31:0] perf_flush1;

  int n_cmp;
  int n_err;
  int deliv_cnt;
  bit seen_40;
  logic [31:0] exp_perf;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_en_o   (imem_rd_en_o),
    .imem_addr_o    (imem_addr_o),
    .imem_rdata_i   (imem_rdata_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .perf_fetched_o (perf_fetched_o),
    .perf_flush_o   (perf_flush_o)
  );

  fetch_stage #(.RESET_PC(RESET_PC1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_en_o   (rd_en1),
    .imem_addr_o    (addr1),
    .imem_rdata_i   (rdata1),
    .redirect_i     (redirect1),
    .redirect_pc_i  (redirect_pc1),
    .valid_o        (valid1),
    .ready_i        (ready1),
    .instr_o        (instr1),
    .pc_o           (pc1),
    .perf_fetched_o (perf_fetched1),
    .perf_flush_o   (perf_flush1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memories: word at address A is ~A.
  always @(posedge clk) if (imem_rd_en_o) imem_rdata_i <= ~imem_addr_o;
  always @(posedge clk) if (rd_en1) rdata1 <= ~addr1;

  // Delivery monitor for dut, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) deliv_cnt = 0;
    else if (valid_o && ready_i) begin
      deliv_cnt = deliv_cnt + 1;
      if (pc_o >= 32'h40 && pc_o <= 32'h7C) seen_40 = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    ready1 = 1'b1; redirect1 = 1'b0; redirect_pc1 = '0;
    repeat (3) tick();
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_cmp++; if (imem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b expected 0", imem_rd_en_o); end
    n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL reset_valid1: got %b expected 0", valid1); end
    n_cmp++; if (perf_fetched_o !== 32'd0) begin n_err++; $display("FAIL reset_perf_fetched: got %0d expected 0", perf_fetched_o); end
    n_cmp++; if (perf_flush_o !== 32'd0) begin n_err++; $display("FAIL reset_perf_flush: got %0d expected 0", perf_flush_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_rd_en_o !== 1'b1) begin n_err++; $display("FAIL first_rd_en: got %b expected 1", imem_rd_en_o); end
    n_cmp++; if (imem_addr_o !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h expected 00000000", imem_addr_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL first_valid: got %b expected 0", valid_o); end
    n_cmp++; if (addr1 !== RESET_PC1) begin n_err++; $display("FAIL first_addr1: got %h expected %h", addr1, RESET_PC1); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    logic [31:0] e1;
    for (int c = 1; c < 8; c++) begin
      tick();
      if (c == 1) begin
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL stream_c1_valid: got %b expected 0", valid_o); end
        n_cmp++; if (imem_addr_o !== 32'h4) begin n_err++; $display("FAIL stream_c1_addr: got %h expected 00000004", imem_addr_o); end
      end else begin
        e = 32'(4 * (c - 2));
        n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid c%0d: got %b expected 1", c, valid_o); end
        n_cmp++; if (pc_o !== e) begin n_err++; $display("FAIL stream_pc c%0d: got %h expected %h", c, pc_o, e); end
        n_cmp++; if (instr_o !== ~e) begin n_err++; $display("FAIL stream_instr c%0d: got %h expected %h", c, instr_o, ~e); end
      end
      if (c >= 2 && c <= 4) begin
        e1 = RESET_PC1 + 32'(4 * (c - 2));
        n_cmp++; if (pc1 !== e1) begin n_err++; $display("FAIL wrap_pc c%0d: got %h expected %h", c, pc1, e1); end
      end
      if (c == 5) begin
`ifdef FETCH_PERF_CNT_EN
        exp_perf = 32'd3;
`else
        exp_perf = 32'd0;
`endif
        n_cmp++; if (perf_fetched1 !== exp_perf) begin n_err++; $display("FAIL wrap_perf_fetched: got %0d expected %0d", perf_fetched1, exp_perf); end
      end
    end
  endtask

  task automatic test_stall();
    tick();
    ready_i = 1'b0;
    #1;
    n_cmp++; if (imem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL stall_rd_en0: got %b expected 0", imem_rd_en_o); end
    n_cmp++; if (pc_o !== 32'd24) begin n_err++; $display("FAIL stall_head: got %h expected 00000018", pc_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL stall_valid %0d: got %b expected 1", i, valid_o); end
      n_cmp++; if (pc_o !== 32'd24) begin n_err++; $display("FAIL stall_pc %0d: got %h expected 00000018", i, pc_o); end
      n_cmp++; if (instr_o !== ~32'd24) begin n_err++; $display("FAIL stall_instr %0d: got %h expected %h", i, instr_o, ~32'd24); end
      n_cmp++; if (imem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL stall_rd_en %0d: got %b expected 0", i, imem_rd_en_o); end
    end
    tick();
    ready_i = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL resume_valid %0d: got %b expected 1", j, valid_o); end
      n_cmp++; if (pc_o !== 32'(24 + 4 * j)) begin n_err++; $display("FAIL resume_pc %0d: got %h expected %h", j, pc_o, 32'(24 + 4 * j)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b expected 0", valid_o); end
    n_cmp++; if (imem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL redir_rd_en: got %b expected 0", imem_rd_en_o); end
    tick();
    redirect_i = 1'b0;
    #1;
    n_cmp++; if (imem_rd_en_o !== 1'b1) begin n_err++; $display("FAIL redir_issue: got %b expected 1", imem_rd_en_o); end
    n_cmp++; if (imem_addr_o !== 32'h100) begin n_err++; $display("FAIL redir_addr: got %h expected 00000100", imem_addr_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL redir_valid1: got %b expected 0", valid_o); end
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL redir_valid2: got %b expected 0", valid_o); end
    n_cmp++; if (imem_addr_o !== 32'h104) begin n_err++; $display("FAIL redir_addr2: got %h expected 00000104", imem_addr_o); end
    tick();
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL redir_valid3: got %b expected 1", valid_o); end
    n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL redir_pc: got %h expected 00000100", pc_o); end
    n_cmp++; if (instr_o !== ~32'h100) begin n_err++; $display("FAIL redir_instr: got %h expected %h", instr_o, ~32'h100); end
    tick();
    n_cmp++; if (pc_o !== 32'h104) begin n_err++; $display("FAIL redir_pc2: got %h expected 00000104", pc_o); end
  endtask

  task automatic test_redirect_unaligned();
    redirect_i = 1'b1; redirect_pc_i = 32'h203;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL unal_valid: got %b expected 0", valid_o); end
    tick();
    redirect_i = 1'b0;
    #1;
    n_cmp++; if (imem_addr_o !== 32'h200) begin n_err++; $display("FAIL unal_addr: got %h expected 00000200", imem_addr_o); end
    tick();
    tick();
    n_cmp++; if (pc_o !== 32'h200) begin n_err++; $display("FAIL unal_pc: got %h expected 00000200", pc_o); end
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL unal_valid2: got %b expected 1", valid_o); end
    tick();
    n_cmp++; if (pc_o !== 32'h204) begin n_err++; $display("FAIL unal_pc2: got %h expected 00000204", pc_o); end
  endtask

  task automatic test_back_to_back();
    seen_40 = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_valid0: got %b expected 0", valid_o); end
    tick();
    redirect_pc_i = 32'h80;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_valid1: got %b expected 0", valid_o); end
    n_cmp++; if (imem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL b2b_rd_en: got %b expected 0", imem_rd_en_o); end
    tick();
    redirect_i = 1'b0;
    #1;
    n_cmp++; if (imem_addr_o !== 32'h80) begin n_err++; $display("FAIL b2b_addr: got %h expected 00000080", imem_addr_o); end
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_valid2: got %b expected 0", valid_o); end
    tick();
    n_cmp++; if (pc_o !== 32'h80) begin n_err++; $display("FAIL b2b_pc: got %h expected 00000080", pc_o); end
    tick();
    n_cmp++; if (pc_o !== 32'h84) begin n_err++; $display("FAIL b2b_pc2: got %h expected 00000084", pc_o); end
    n_cmp++; if (seen_40 !== 1'b0) begin n_err++; $display("FAIL b2b_stale: got %b expected 0", seen_40); end
`ifdef FETCH_PERF_CNT_EN
    exp_perf = 32'd4;
`else
    exp_perf = 32'd0;
`endif
    n_cmp++; if (perf_flush_o !== exp_perf) begin n_err++; $display("FAIL perf_flush: got %0d expected %0d", perf_flush_o, exp_perf); end
`ifdef FETCH_PERF_CNT_EN
    exp_perf = 32'(deliv_cnt);
`else
    exp_perf = 32'd0;
`endif
    n_cmp++; if (perf_fetched_o !== exp_perf) begin n_err++; $display("FAIL perf_fetched: got %0d expected %0d", perf_fetched_o, exp_perf); end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h300; rst = 1'b1;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", valid_o); end
    n_cmp++; if (imem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL rmid_rd_en: got %b expected 0", imem_rd_en_o); end
    tick();
    n_cmp++; if (perf_flush_o !== 32'd0) begin n_err++; $display("FAIL rmid_perf_flush: got %0d expected 0", perf_flush_o); end
    n_cmp++; if (perf_fetched_o !== 32'd0) begin n_err++; $display("FAIL rmid_perf_fetched: got %0d expected 0", perf_fetched_o); end
    redirect_i = 1'b0; ready_i = 1'b1; rst = 1'b0;
    #1;
    n_cmp++; if (imem_addr_o !== 32'h0) begin n_err++; $display("FAIL rmid_addr: got %h expected 00000000", imem_addr_o); end
    n_cmp++; if (imem_rd_en_o !== 1'b1) begin n_err++; $display("FAIL rmid_issue: got %b expected 1", imem_rd_en_o); end
    tick();
    tick();
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL rmid_valid2: got %b expected 1", valid_o); end
    n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL rmid_pc: got %h expected 00000000", pc_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    deliv_cnt = 0;
    seen_40 = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_unaligned();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
